// File: rtl/fp_cmp_pkg.sv
//==============================================================================
// Module      : fp_cmp_pkg
// Description : Shared types and helpers for the FP compare / min-max unit.
//               - fp_cmp_op_e   : opcode encoding (FMIN, FMAX, FLT, FEQ, FLE)
//               - FFLAG_NV      : bit index of the invalid-operation flag
//               - fp_class_t    : per-operand classification
//               - canonical_nan : canonical quiet NaN for a given width
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package fp_cmp_pkg;

  typedef enum logic [2:0] {
    FMIN = 3'd0,
    FMAX = 3'd1,
    FLT  = 3'd2,
    FEQ  = 3'd3,
    FLE  = 3'd4
  } fp_cmp_op_e;

  // fflags layout is {NV, DZ, OF, UF, NX}
  localparam int FFLAG_NV = 4;

  typedef struct packed {
    logic is_nan;
    logic is_snan;
    logic is_zero;
    logic sign;
  } fp_class_t;

  // Canonical quiet NaN, returned right-aligned in 64 bits.
  function automatic logic [63:0] canonical_nan(input int flen);
    if (flen == 64) begin
      return 64'h7FF8_0000_0000_0000;
    end
    return 64'h0000_0000_7FC0_0000;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_classify.sv
//==============================================================================
// Module      : fp_classify
// Description : Combinational classification of one IEEE-754 operand.
// Ports       : operand - raw floating-point bit pattern (FLEN bits)
//               cls     - {is_nan, is_snan, is_zero, sign}
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fp_classify
  import fp_cmp_pkg::*;
#(
  parameter int FLEN  = 32,
  parameter int EXP_W = 8
) (
  input  logic [FLEN-1:0] operand,
  output fp_class_t       cls
);

  localparam int MAN_W = FLEN - 1 - EXP_W;

  logic [EXP_W-1:0] w_exp;
  logic [MAN_W-1:0] w_man;
  logic             w_exp_ones;
  logic             w_exp_zero;
  logic             w_man_zero;

  assign w_exp      = operand[FLEN-2 -: EXP_W];
  assign w_man      = operand[MAN_W-1:0];
  assign w_exp_ones = &w_exp;
  assign w_exp_zero = ~|w_exp;
  assign w_man_zero = ~|w_man;

  assign cls.is_nan  = w_exp_ones & ~w_man_zero;
  // Signalling NaNs have the quiet bit (mantissa MSB) clear.
  assign cls.is_snan = w_exp_ones & ~w_man_zero & ~w_man[MAN_W-1];
  assign cls.is_zero = w_exp_zero & w_man_zero;
  assign cls.sign    = operand[FLEN-1];

endmodule

`default_nettype wire

// File: rtl/fp_compare_unit.sv
//==============================================================================
// Module      : fp_compare_unit
// Description : Two-stage pipelined FP compare / min-max unit (FMIN, FMAX,
//               FLT, FEQ, FLE) with RISC-V NaN and signed-zero semantics.
//               S1 registers classification and raw ordering, S2 registers
//               the final result and exception flags.
// Ports       : i_clk, i_rst          - clock, async active-high reset
//               i_valid / o_ready     - operation handshake
//               i_op, i_rs1_f, i_rs2_f, i_tag - operation and sideband tag
//               o_valid / i_ready     - result handshake
//               o_result, o_fflags, o_tag     - result, {NV,DZ,OF,UF,NX}, tag
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fp_compare_unit
  import fp_cmp_pkg::*;
#(
  parameter int FLEN  = 32,
  parameter int EXP_W = 8,
  parameter int TAG_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_op,
  input  logic [FLEN-1:0]  i_rs1_f,
  input  logic [FLEN-1:0]  i_rs2_f,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [FLEN-1:0]  o_result,
  output logic [4:0]       o_fflags,
  output logic [TAG_W-1:0] o_tag
);

  localparam logic [FLEN-1:0] C_CANON_NAN = FLEN'(canonical_nan(FLEN));

  //--------------------------------------------------------------------------
  // Handshake
  //--------------------------------------------------------------------------
  logic w_s2_can_load;
  logic w_accept;
  logic r_s1_valid;

  assign w_s2_can_load = ~o_valid | i_ready;
  assign o_ready       = ~r_s1_valid | w_s2_can_load;
  assign w_accept      = i_valid & o_ready;

  //--------------------------------------------------------------------------
  // Classification and raw ordering (feeds S1)
  //--------------------------------------------------------------------------
  fp_class_t w_cls_a;
  fp_class_t w_cls_b;

  fp_classify #(
    .FLEN  (FLEN),
    .EXP_W (EXP_W)
  ) u_cls_a (
    .operand (i_rs1_f),
    .cls     (w_cls_a)
  );

  fp_classify #(
    .FLEN  (FLEN),
    .EXP_W (EXP_W)
  ) u_cls_b (
    .operand (i_rs2_f),
    .cls     (w_cls_b)
  );

  logic w_mag_lt;
  logic w_mag_eq;
  logic w_both_zero;
  logic w_sign_diff;
  logic w_neg_lt;
  logic w_lt;
  logic w_eq;
  logic w_lt_tot;

  // Magnitude on {exp,mant}; the sign is folded in afterwards.
  assign w_mag_lt    = i_rs1_f[FLEN-2:0] < i_rs2_f[FLEN-2:0];
  assign w_mag_eq    = i_rs1_f[FLEN-2:0] == i_rs2_f[FLEN-2:0];
  assign w_both_zero = w_cls_a.is_zero & w_cls_b.is_zero;
  assign w_sign_diff = w_cls_a.sign ^ w_cls_b.sign;
  // Both negative: larger magnitude is the smaller value.
  assign w_neg_lt    = ~w_mag_lt & ~w_mag_eq;

  // IEEE ordering used by FLT/FEQ/FLE: -0 and +0 compare equal.
  assign w_lt = w_sign_diff ? (w_cls_a.sign & ~w_both_zero)
                            : (w_cls_a.sign ? w_neg_lt : w_mag_lt);
  assign w_eq = (w_mag_eq & ~w_sign_diff) | w_both_zero;

  // Total ordering used by FMIN/FMAX: -0 sorts below +0.
  assign w_lt_tot = w_sign_diff ? w_cls_a.sign
                                : (w_cls_a.sign ? w_neg_lt : w_mag_lt);

  //--------------------------------------------------------------------------
  // Stage S1
  //--------------------------------------------------------------------------
  logic [2:0]       r_s1_op;
  logic [TAG_W-1:0] r_s1_tag;
  logic [FLEN-1:0]  r_s1_a;
  logic [FLEN-1:0]  r_s1_b;
  logic             r_s1_a_nan;
  logic             r_s1_a_snan;
  logic             r_s1_b_nan;
  logic             r_s1_b_snan;
  logic             r_s1_lt;
  logic             r_s1_eq;
  logic             r_s1_lt_tot;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_op     <= '0;
      r_s1_tag    <= '0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_a_nan  <= 1'b0;
      r_s1_a_snan <= 1'b0;
      r_s1_b_nan  <= 1'b0;
      r_s1_b_snan <= 1'b0;
      r_s1_lt     <= 1'b0;
      r_s1_eq     <= 1'b0;
      r_s1_lt_tot <= 1'b0;
    end else begin
      if (o_ready) begin
        r_s1_valid <= i_valid;
      end
      if (w_accept) begin
        r_s1_op     <= i_op;
        r_s1_tag    <= i_tag;
        r_s1_a      <= i_rs1_f;
        r_s1_b      <= i_rs2_f;
        r_s1_a_nan  <= w_cls_a.is_nan;
        r_s1_a_snan <= w_cls_a.is_snan;
        r_s1_b_nan  <= w_cls_b.is_nan;
        r_s1_b_snan <= w_cls_b.is_snan;
        r_s1_lt     <= w_lt;
        r_s1_eq     <= w_eq;
        r_s1_lt_tot <= w_lt_tot;
      end
    end
  end

  //--------------------------------------------------------------------------
  // Result selection (feeds S2)
  //--------------------------------------------------------------------------
  logic            w_any_nan;
  logic            w_any_snan;
  logic            w_pick_a;
  logic            w_nv;
  logic [FLEN-1:0] w_result;
  logic [4:0]      w_fflags;

  assign w_any_nan  = r_s1_a_nan | r_s1_b_nan;
  assign w_any_snan = r_s1_a_snan | r_s1_b_snan;
  // On equal values a and b are bit-identical, so either pick is correct.
  assign w_pick_a   = (r_s1_op == FMIN) ? r_s1_lt_tot : ~r_s1_lt_tot;

  always_comb begin
    w_nv     = 1'b0;
    w_result = '0;
    w_fflags = '0;
    case (fp_cmp_op_e'(r_s1_op))
      FMIN, FMAX: begin
        w_nv = w_any_snan;
        if (r_s1_a_nan & r_s1_b_nan) begin
          w_result = C_CANON_NAN;
        end else if (r_s1_a_nan) begin
          w_result = r_s1_b;
        end else if (r_s1_b_nan) begin
          w_result = r_s1_a;
        end else begin
          w_result = w_pick_a ? r_s1_a : r_s1_b;
        end
      end
      FLT: begin
        w_nv     = w_any_nan;
        w_result = {{(FLEN-1){1'b0}}, ~w_any_nan & r_s1_lt};
      end
      FLE: begin
        w_nv     = w_any_nan;
        w_result = {{(FLEN-1){1'b0}}, ~w_any_nan & (r_s1_lt | r_s1_eq)};
      end
      FEQ: begin
        // Quiet compare: only signalling NaNs raise NV.
        w_nv     = w_any_snan;
        w_result = {{(FLEN-1){1'b0}}, ~w_any_nan & r_s1_eq};
      end
      default: begin
        w_nv     = 1'b0;
        w_result = '0;
      end
    endcase
    w_fflags[FFLAG_NV] = w_nv;
  end

  //--------------------------------------------------------------------------
  // Stage S2 (output registers)
  //--------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid  <= 1'b0;
      o_result <= '0;
      o_fflags <= '0;
      o_tag    <= '0;
    end else begin
      if (w_s2_can_load) begin
        o_valid <= r_s1_valid;
      end
      if (r_s1_valid & w_s2_can_load) begin
        o_result <= w_result;
        o_fflags <= w_fflags;
        o_tag    <= r_s1_tag;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_compare_unit.sv
//==============================================================================
// Module      : tb_fp_compare_unit
// Description : Self-checking bench for fp_compare_unit (FLEN=32 and FLEN=64
//               instances) with a value-ordering reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fp_compare_unit;
  import fp_cmp_pkg::*;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  fl;
    logic [4:0]  tag;
  } exp_t;

  int n_checks = 0;
  int n_errors = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // FLEN=32 instance
  logic        in_valid = 1'b0;
  logic        out_ready;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] rs2 = 32'd0;
  logic [4:0]  tag_in = 5'd0;
  logic        out_valid;
  logic        cons_ready = 1'b1;
  logic [31:0] result;
  logic [4:0]  fflags;
  logic [4:0]  tag_out;

  // FLEN=64 instance
  logic        v64 = 1'b0;
  logic        ordy64;
  logic [2:0]  op64 = 3'd0;
  logic [63:0] a64 = 64'd0;
  logic [63:0] b64 = 64'd0;
  logic [4:0]  tag64 = 5'd0;
  logic        ov64;
  logic        crdy64 = 1'b1;
  logic [63:0] res64;
  logic [4:0]  ff64;
  logic [4:0]  tg64;

  exp_t       q[$];
  logic [4:0] out_tags[$];

  always #5 clk = ~clk;

  fp_compare_unit #(.FLEN(32), .EXP_W(8), .TAG_W(5)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(out_ready),
    .i_op(op), .i_rs1_f(rs1), .i_rs2_f(rs2), .i_tag(tag_in),
    .o_valid(out_valid), .i_ready(cons_ready), .o_result(result),
    .o_fflags(fflags), .o_tag(tag_out)
  );

  fp_compare_unit #(.FLEN(64), .EXP_W(11), .TAG_W(5)) dut64 (
    .i_clk(clk), .i_rst(rst), .i_valid(v64), .o_ready(ordy64),
    .i_op(op64), .i_rs1_f(a64), .i_rs2_f(b64), .i_tag(tag64),
    .o_valid(ov64), .i_ready(crdy64), .o_result(res64),
    .o_fflags(ff64), .o_tag(tg64)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: map each value onto a signed integer line. "key" merges the
  // two zeros (IEEE compare); "keyt" places -0 just below +0 (min/max).
  task automatic decode(input int flen, input logic [63:0] x, output bit nan,
                        output bit snan, output longint key, output longint keyt);
    int ew = (flen == 64) ? 11 : 8;
    int mw = flen - 1 - ew;
    longint unsigned e = (x >> mw) & ((64'd1 << ew) - 1);
    longint unsigned m = x & ((64'd1 << mw) - 1);
    longint mag = longint'(x & ((64'd1 << (flen - 1)) - 1));
    bit s = x[flen-1];
    nan  = (e == (64'd1 << ew) - 1) && (m != 0);
    snan = nan && (((m >> (mw - 1)) & 1) == 0);
    key  = s ? -mag : mag;
    keyt = s ? -mag - 1 : mag;
  endtask

  task automatic ref_model(input int flen, input logic [2:0] o, input logic [63:0] a,
                           input logic [63:0] b, output logic [63:0] res, output logic [4:0] fl);
    bit na, sa, nb, sb, nv;
    longint ka, kta, kb, ktb;
    decode(flen, a, na, sa, ka, kta);
    decode(flen, b, nb, sb, kb, ktb);
    res = 64'd0;
    nv  = 1'b0;
    case (o)
      3'd0, 3'd1: begin
        nv = sa || sb;
        if (na && nb)  res = (flen == 64) ? 64'h7FF8_0000_0000_0000 : 64'h7FC0_0000;
        else if (na)   res = b;
        else if (nb)   res = a;
        else if (o == 3'd0) res = (kta <= ktb) ? a : b;
        else           res = (kta >= ktb) ? a : b;
      end
      3'd2: begin nv = na || nb; res = {63'd0, !(na || nb) && (ka <  kb)}; end
      3'd3: begin nv = sa || sb; res = {63'd0, !(na || nb) && (ka == kb)}; end
      3'd4: begin nv = na || nb; res = {63'd0, !(na || nb) && (ka <= kb)}; end
      default: begin nv = 1'b0; res = 64'd0; end
    endcase
    fl = {nv, 4'b0000};
  endtask

  function automatic logic [63:0] gen_op(input int flen);
    int ew = (flen == 64) ? 11 : 8;
    int mw = flen - 1 - ew;
    logic [63:0] r    = {$urandom, $urandom};
    logic [63:0] emax = (64'd1 << ew) - 1;
    logic [63:0] mmsk = (64'd1 << mw) - 1;
    logic [63:0] wmsk = (flen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
    logic [63:0] sgn  = ($urandom_range(0, 1) == 1) ? (64'd1 << (flen - 1)) : 64'd0;
    logic [63:0] e, m;
    case ($urandom_range(0, 7))
      0: begin e = 0;    m = 0; end
      1: begin e = emax; m = 0; end
      2: begin e = emax; m = (64'd1 << (mw - 1)) | (r & mmsk); end
      3: begin e = emax; m = (r & (mmsk >> 1)) | 64'd1; end
      4: begin e = emax >> 1; m = r & 64'd3; end
      5: begin e = (emax >> 1) + (r >> 63); m = 0; end
      default: return r & wmsk;
    endcase
    return sgn | (e << mw) | m;
  endfunction

  // One cycle on the 32-bit unit: drive at negedge, then score both
  // handshakes that will complete on the next rising edge.
  task automatic step(input logic v, input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] t, input logic rdy,
                      output logic acc);
    exp_t e;
    logic [63:0] r;
    logic [4:0]  f;
    @(negedge clk);
    in_valid = v; op = o; rs1 = a; rs2 = b; tag_in = t; cons_ready = rdy;
    #1;
    if (out_valid && cons_ready) begin
      chk("sb_entry", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("result", 64'(result), e.res);
        chk("fflags", 64'(fflags), 64'(e.fl));
        chk("tag", 64'(tag_out), 64'(e.tag));
        out_tags.push_back(tag_out);
      end
    end
    acc = v && out_ready;
    if (acc) begin
      ref_model(32, o, 64'(a), 64'(b), r, f);
      e.res = r; e.fl = f; e.tag = t;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    logic acc;
    int n = 0;
    while ((q.size() > 0 || out_valid) && n < 20) begin
      step(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b1, acc);
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic directed(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic nv);
    logic acc;
    drain();
    step(1'b1, o, a, b, 5'd9, 1'b1, acc);
    chk({name, "_acc"}, 64'(acc), 64'd1);
    step(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b1, acc);
    chk({name, "_lat1"}, 64'(out_valid), 64'd0);
    step(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b1, acc);
    chk({name, "_lat2"}, 64'(out_valid), 64'd1);
    chk({name, "_res"}, 64'(result), 64'(er));
    chk({name, "_ff"}, 64'(fflags), {59'd0, nv, 4'd0});
  endtask

  task automatic run64(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] t);
    logic [63:0] r;
    logic [4:0]  f;
    ref_model(64, o, a, b, r, f);
    @(negedge clk);
    v64 = 1'b1; op64 = o; a64 = a; b64 = b; tag64 = t;
    #1 chk("d64_ready", 64'(ordy64), 64'd1);
    @(negedge clk);
    v64 = 1'b0;
    #1 chk("d64_lat1", 64'(ov64), 64'd0);
    @(negedge clk);
    #1 chk("d64_lat2", 64'(ov64), 64'd1);
    chk("d64_res", res64, r);
    chk("d64_ff", 64'(ff64), 64'(f));
    chk("d64_tag", 64'(tg64), 64'(t));
  endtask

  initial begin
    logic        acc;
    logic [63:0] ta, tb;
    logic [31:0] held_res;
    logic [4:0]  held_tag;
    logic [4:0]  t;
    int          n;

    // Reset state
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_fflags", 64'(fflags), 64'd0);
    chk("rst_tag", 64'(tag_out), 64'd0);
    chk("rst_valid64", 64'(ov64), 64'd0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    step(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b1, acc);
    chk("rst_ready", 64'(out_ready), 64'd1);

    // Directed cases
    directed("flt_1_2",    FLT,  32'h3F80_0000, 32'h4000_0000, 32'h1,         1'b0);
    directed("fmin_zeros", FMIN, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0);
    directed("fmax_zeros", FMAX, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
    directed("feq_zeros",  FEQ,  32'h8000_0000, 32'h0000_0000, 32'h1,         1'b0);
    directed("fmax_2nan",  FMAX, 32'h7F80_0001, 32'h7FC0_0001, 32'h7FC0_0000, 1'b1);
    directed("fmin_qnan",  FMIN, 32'h7FC0_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
    directed("feq_qnan",   FEQ,  32'h7FC0_0000, 32'h3F80_0000, 32'h0,         1'b0);
    directed("fle_qnan",   FLE,  32'h7FC0_0000, 32'h3F80_0000, 32'h0,         1'b1);
    directed("undef_op",   3'd6, 32'h7F80_0001, 32'h3F80_0000, 32'h0,         1'b0);

    // Back-to-back with output stall
    drain();
    out_tags.delete();
    ta = gen_op(32); tb = gen_op(32);
    step(1'b1, FLT, ta[31:0], tb[31:0], 5'd1, 1'b0, acc);
    chk("stall_acc1", 64'(acc), 64'd1);
    step(1'b1, FMAX, ta[31:0], tb[31:0], 5'd2, 1'b0, acc);
    chk("stall_acc2", 64'(acc), 64'd1);
    step(1'b1, FLE, tb[31:0], ta[31:0], 5'd3, 1'b0, acc);
    chk("stall_ready_drop", 64'(out_ready), 64'd0);
    chk("stall_head_tag", 64'(tag_out), 64'd1);
    held_res = result;
    held_tag = tag_out;
    repeat (2) begin
      step(1'b1, FLE, tb[31:0], ta[31:0], 5'd3, 1'b0, acc);
      chk("stall_hold_res", 64'(result), 64'(held_res));
      chk("stall_hold_tag", 64'(tag_out), 64'(held_tag));
      chk("stall_ready_low", 64'(out_ready), 64'd0);
    end
    t = 5'd3;
    n = 0;
    while (t <= 5'd4 && n < 20) begin
      step(1'b1, (t == 5'd3) ? FLE : FMIN, tb[31:0], ta[31:0], t, 1'b1, acc);
      if (acc) t = t + 5'd1;
      n++;
    end
    drain();
    chk("stall_count", 64'(out_tags.size()), 64'd4);
    for (int i = 0; i < 4 && i < out_tags.size(); i++) begin
      chk("stall_order", 64'(out_tags[i]), 64'(i + 1));
    end

    // Randomized traffic with random back-pressure (includes undefined ops)
    for (int i = 0; i < 400; i++) begin
      ta = gen_op(32);
      tb = ($urandom_range(0, 5) == 0) ? ta : gen_op(32);
      step($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), ta[31:0], tb[31:0],
           5'($urandom), $urandom_range(0, 3) != 0, acc);
    end
    drain();

    // Reset with operations in flight
    step(1'b1, FLT, 32'h3F80_0000, 32'h4000_0000, 5'd11, 1'b1, acc);
    step(1'b1, FLE, 32'h3F80_0000, 32'h4000_0000, 5'd12, 1'b1, acc);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("inflight_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1 chk("async_rst_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    step(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b1, acc);
    chk("post_rst_ready", 64'(out_ready), 64'd1);
    repeat (5) begin
      step(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b1, acc);
      chk("post_rst_no_stale", 64'(out_valid), 64'd0);
    end

    // FLEN=64 instance
    run64(FLT, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 5'd1);
    run64(FMAX, 64'h7FF0_0000_0000_0001, 64'h7FF8_0000_0000_0001, 5'd2);
    run64(FMIN, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000, 5'd3);
    for (int i = 0; i < 40; i++) begin
      ta = gen_op(64);
      tb = ($urandom_range(0, 5) == 0) ? ta : gen_op(64);
      run64(3'($urandom_range(0, 7)), ta, tb, 5'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fp_compare_unit.md
Name: fp_compare_unit

Overview:
- Pipelined successor to the combinational FP compare/min-max flag selector.
- Classifies both operands and compares them internally; no external greater/less/equal/NaN flags are needed.
- Handles FMIN, FMAX, FLT, FEQ and FLE with full RISC-V F/D NaN and signed-zero semantics and raises the NV exception flag.
- Parametrised in float format; sits in the FPU execute stage behind a valid/ready handshake.

Parameters:
- FLEN, 32, operand width (32 or 64).
- EXP_W, 8, exponent width (11 when FLEN=64).
- TAG_W, 5, width of the sideband tag carried alongside each operation (destination register index).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; asynchronous, active-high.
- i_valid  in  1  operation offered.
- o_ready  out  1  unit can accept an operation this cycle.
- i_op  in  3  opcode of type fp_cmp_op_e.
- i_rs1_f  in  FLEN  operand A.
- i_rs2_f  in  FLEN  operand B.
- i_tag  in  TAG_W  sideband tag.
- o_valid  out  1  result available.
- i_ready  in  1  consumer accepts the result.
- o_result  out  FLEN  min/max value, or compare result zero-extended (0 or 1).
- o_fflags  out  5  {NV,DZ,OF,UF,NX}; only NV is ever set.
- o_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset: clock and reset are as already decided (one clock i_clk; asynchronous, active-high i_rst).
  - Stage valids, o_valid, o_result, o_fflags and o_tag all reset to 0.
  - o_ready is 1 one cycle after reset deasserts.
  - Operations in flight when reset asserts are discarded, not completed.
- Pipeline: two register stages, S1 and S2.
  - S1 captures the op, tag, classify results and the raw compare (lt, eq, sign-aware).
  - S2 captures the final result and flags.
  - Latency is 2 cycles from acceptance (i_valid & o_ready) to o_valid. Throughput is 1 op per cycle.
- Handshake:
  - A stage loads when it is empty or its content moves downstream in the same cycle.
  - o_ready = !S1_valid | S2_can_load, where S2_can_load = !o_valid | i_ready.
  - While o_valid & !i_ready, o_result, o_fflags and o_tag are held stable.
  - No combinational path from i_valid to o_valid.
  - A path from i_ready to o_ready is permitted.
- Classification (per operand):
  - NaN: exponent is all ones and mantissa != 0.
  - sNaN: NaN with mantissa MSB = 0.
  - Zero: exponent = 0 and mantissa = 0.
- Ordering:
  - For FLT/FEQ/FLE: -0 == +0.
  - For FMIN/FMAX: -0 < +0.
  - Magnitude compare is done on {exp,mant}, with the sign applied afterwards.
- FLT / FLE:
  - Either operand NaN -> result 0, NV = 1.
  - Otherwise result = lt (FLT) or lt|eq (FLE).
- FEQ:
  - Either operand sNaN -> NV = 1.
  - Either operand NaN -> result 0.
  - Otherwise result = eq.
- FMIN / FMAX:
  - Either operand sNaN -> NV = 1.
  - Both NaN -> canonical NaN (FLEN=32: 0x7FC0_0000; FLEN=64: 0x7FF8_0000_0000_0000).
  - One NaN -> the other operand.
  - Otherwise the smaller (FMIN) or larger (FMAX) operand.
- Undefined opcodes: result 0, fflags 0; the op still flows through the pipeline and produces o_valid.
- o_fflags[3:0] are always 0.

Decomposition:
- Package fp_cmp_pkg holds:
  - fp_cmp_op_e: FMIN=0, FMAX=1, FLT=2, FEQ=3, FLE=4.
  - The FFLAG_NV bit index.
  - A canonical_nan(FLEN) function.
  - The fp_class_t struct {is_nan, is_snan, is_zero, sign}.
- One sub-module, fp_classify, parameterised on FLEN/EXP_W, instantiated once per operand.

Test Plan:
- FLT, rs1=0x3F800000 (1.0), rs2=0x40000000 (2.0), i_ready=1 -> o_valid 2 cycles later, o_result=1, o_fflags=0.
- FMIN, rs1=0x80000000 (-0), rs2=0x00000000 (+0) -> o_result=0x80000000. FEQ on the same operands -> result 1.
- FMAX, rs1=0x7F800001 (sNaN), rs2=0x7FC00001 (qNaN) -> o_result=0x7FC00000, NV=1. FMIN, qNaN vs 0x3F800000 -> 0x3F800000, NV=0.
- FEQ, rs1=qNaN 0x7FC00000, rs2=1.0 -> result 0, NV=0. FLE on the same operands -> result 0, NV=1.
- Back-to-back ops with tags 1..4, i_ready held low for 3 cycles:
  - o_ready drops after 2 accepts.
  - Output is held stable during the stall.
  - Results emerge in order with tags 1..4 and no loss or duplication.
- Assert i_rst with 2 ops in flight:
  - o_valid=0 immediately (asynchronously).
  - After release, o_ready=1 and no stale result appears.
  - Repeat the single-op check with FLEN=64 (1.0 = 0x3FF0000000000000).
